// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: one outstanding imem request feeding a DEPTH-entry {inst, pc} FIFO.
// Optional FETCH_BUFFER_BYPASS_EN forwards a response straight to decode when the FIFO is empty.
module fetch_buffer #(
  parameter int unsigned DBITS = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DBITS-1:0]         pcIn,
  input  logic                     pcValid,
  output logic                     pcReady,
  output logic [DBITS-1:0]         imemAddr,
  output logic                     imemReq,
  input  logic                     imemGnt,
  input  logic [DBITS-1:0]         imemRdata,
  input  logic                     imemRvalid,
  input  logic                     flush,
  output logic [DBITS-1:0]         instOut,
  output logic [DBITS-1:0]         instPc,
  output logic                     instValid,
  input  logic                     instReady,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDrain} state_e;

  state_e            state_q, state_d;
  logic [DBITS-1:0]  addr_q, addr_d;
  logic [DBITS-1:0]  data_mem [DEPTH];
  logic [DBITS-1:0]  pc_mem   [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;

  logic full, empty, accept, rsp_ok, bypass_take, push, pop;

  assign full    = (count_q == FullCnt);
  assign empty   = (count_q == '0);
  assign pcReady = (state_q == StIdle) && !full && !flush && !reset;
  assign accept  = pcValid && pcReady;
  assign rsp_ok  = (state_q == StWait) && imemRvalid && !flush;

`ifdef FETCH_BUFFER_BYPASS_EN
  assign bypass_take = rsp_ok && empty && instReady;
`else
  assign bypass_take = 1'b0;
`endif

  assign push = rsp_ok && !full && !bypass_take;
  assign pop  = instReady && !empty;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    imemReq = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          addr_d  = pcIn;
          state_d = StReq;
        end
      end
      StReq: begin
        imemReq = 1'b1;
        // A grant that coincides with flush is already in flight; drain its response.
        if (imemGnt)    state_d = flush ? StDrain : StWait;
        else if (flush) state_d = StIdle;
      end
      StWait: begin
        if (imemRvalid) state_d = StIdle;
        else if (flush) state_d = StDrain;
      end
      StDrain: begin
        if (imemRvalid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (pop && !push) count_q <= count_q - CntW'(1);
    end
  end

  // Storage needs no reset: outputs are forced to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= imemRdata;
      pc_mem[wr_ptr_q]   <= addr_q;
    end
  end

  always_comb begin
    instValid = !empty;
    instOut   = empty ? '0 : data_mem[rd_ptr_q];
    instPc    = empty ? '0 : pc_mem[rd_ptr_q];
`ifdef FETCH_BUFFER_BYPASS_EN
    if (empty && rsp_ok) begin
      instValid = 1'b1;
      instOut   = imemRdata;
      instPc    = addr_q;
    end
`endif
  end

  assign imemAddr = addr_q;
  assign count    = count_q;

endmodule

// File: tb/tb_fetch_buffer.sv
// Randomized scoreboard bench for fetch_buffer (default build, bypass disabled).
module tb_fetch_buffer;

  localparam int DBITS = 32;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [DBITS-1:0] pcIn;
  logic             pcValid;
  logic             pcReady;
  logic [DBITS-1:0] imemAddr;
  logic             imemReq;
  logic             imemGnt;
  logic [DBITS-1:0] imemRdata;
  logic             imemRvalid;
  logic             flush;
  logic [DBITS-1:0] instOut;
  logic [DBITS-1:0] instPc;
  logic             instValid;
  logic             instReady;
  logic [$clog2(DEPTH):0] count;

  fetch_buffer #(.DBITS(DBITS), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .pcIn      (pcIn),
    .pcValid   (pcValid),
    .pcReady   (pcReady),
    .imemAddr  (imemAddr),
    .imemReq   (imemReq),
    .imemGnt   (imemGnt),
    .imemRdata (imemRdata),
    .imemRvalid(imemRvalid),
    .flush     (flush),
    .instOut   (instOut),
    .instPc    (instPc),
    .instValid (instValid),
    .instReady (instReady),
    .count     (count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DBITS-1:0] pc;
    logic [DBITS-1:0] data;
  } ent_t;

  // Transaction-level model: expected decode stream plus the life of the single fetch.
  ent_t             exp_q[$];
  int               phase;      // 0 no fetch, 1 awaiting grant, 2 awaiting response
  logic             discard;    // current response must be dropped (flushed after grant)
  logic [DBITS-1:0] maddr;
  int               delay;
  logic             ready_exp;
  logic             mon_en;
  int               checks;
  int               errors;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Apply the inputs of the cycle that just ended to the model.
  task automatic step_model();
    if (flush) exp_q.delete();
    case (phase)
      0: if (pcValid && ready_exp) begin
        maddr = pcIn;
        phase = 1;
      end
      1: if (imemGnt) begin
        phase   = 2;
        discard = flush;
        delay   = $urandom_range(0, 3);
      end else if (flush) begin
        phase = 0;
      end
      default: begin
        if (imemRvalid) begin
          if (!flush && !discard) exp_q.push_back('{pc: maddr, data: imemRdata});
          phase   = 0;
          discard = 1'b0;
        end else if (flush) begin
          discard = 1'b1;
        end
      end
    endcase
  endtask

  task automatic drive(input int cyc);
    int rdy_pct;
    rdy_pct   = ((cyc / 200) % 2 == 0) ? 10 : 70;
    pcValid   = ($urandom_range(0, 3) != 0);
    pcIn      = $urandom;
    imemGnt   = ($urandom_range(0, 2) != 0);
    flush     = ($urandom_range(0, 19) == 0);
    instReady = ($urandom_range(0, 99) < rdy_pct);
    imemRdata = $urandom;
    if (phase == 2) begin
      if (delay == 0) imemRvalid = 1'b1;
      else begin
        delay--;
        imemRvalid = 1'b0;
      end
    end else begin
      // Stray responses outside a wait must be ignored.
      imemRvalid = ($urandom_range(0, 7) == 0);
    end
  endtask

  // Monitor: compare every visible output against the model, pop on consume.
  initial begin
    forever begin
      @(negedge clk);
      ready_exp = (phase == 0) && (exp_q.size() < DEPTH) && !flush && !reset;
      if (mon_en) begin
        chk("pcReady", 64'(pcReady), 64'(ready_exp));
        chk("count", 64'(count), 64'(exp_q.size()));
        chk("instValid", 64'(instValid), 64'(exp_q.size() != 0));
        chk("imemReq", 64'(imemReq), 64'(phase == 1));
        chk("imemAddr", 64'(imemAddr), 64'(maddr));
        if (exp_q.size() != 0) begin
          chk("instPc", 64'(instPc), 64'(exp_q[0].pc));
          chk("instOut", 64'(instOut), 64'(exp_q[0].data));
          if (instReady) void'(exp_q.pop_front());
        end else begin
          chk("instPc_empty", 64'(instPc), 64'(0));
          chk("instOut_empty", 64'(instOut), 64'(0));
        end
      end
    end
  end

  initial begin
    logic got;
    checks = 0; errors = 0; mon_en = 1'b0;
    phase = 0; discard = 1'b0; maddr = '0; delay = 0; ready_exp = 1'b0;
    reset = 1'b1; pcIn = '0; pcValid = 1'b0; imemGnt = 1'b0; imemRdata = '0;
    imemRvalid = 1'b0; flush = 1'b0; instReady = 1'b0;

    #1;
    chk("rst_pcReady", 64'(pcReady), 64'(0));
    chk("rst_imemReq", 64'(imemReq), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_instValid", 64'(instValid), 64'(0));
    chk("rst_instOut", 64'(instOut), 64'(0));
    chk("rst_instPc", 64'(instPc), 64'(0));
    chk("rst_imemAddr", 64'(imemAddr), 64'(0));

    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    mon_en = 1'b1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      step_model();
      #1 drive(cyc);
    end

    // Steer into a pending request, then reset asynchronously in the middle of it.
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk);
      step_model();
      if (phase == 1) got = 1'b1;
      else begin
        #1;
        pcValid    = 1'b1;
        imemGnt    = 1'b0;
        flush      = 1'b0;
        instReady  = 1'b1;
        imemRvalid = (phase == 2);
      end
    end
    chk("reach_req", 64'(got), 64'(1));
    #1;
    pcValid = 1'b0; imemGnt = 1'b0; imemRvalid = 1'b0; flush = 1'b0; instReady = 1'b0;
    @(negedge clk);
    #2;
    mon_en = 1'b0;
    reset  = 1'b1;
    #1;
    chk("midrst_imemReq", 64'(imemReq), 64'(0));
    chk("midrst_pcReady", 64'(pcReady), 64'(0));
    chk("midrst_count", 64'(count), 64'(0));
    chk("midrst_instValid", 64'(instValid), 64'(0));
    chk("midrst_instOut", 64'(instOut), 64'(0));
    chk("midrst_instPc", 64'(instPc), 64'(0));
    chk("midrst_imemAddr", 64'(imemAddr), 64'(0));
    phase = 0; discard = 1'b0; maddr = '0;
    exp_q.delete();

    repeat (2) @(posedge clk);
    #1;
    reset      = 1'b0;
    imemRvalid = 1'b1;
    imemRdata  = 32'hdead_beef;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("stray_count", 64'(count), 64'(0));
    chk("stray_instValid", 64'(instValid), 64'(0));
    chk("stray_imemReq", 64'(imemReq), 64'(0));
    chk("stray_pcReady", 64'(pcReady), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
